// File: rtl/rgmii_tx_framer.sv
// rtl/rgmii_tx_framer.sv - GMII-style transmit framer: preamble, SFD, payload, pad, CRC-32 FCS, IFG
// Outputs are registered one cycle behind the state that produces them.
module rgmii_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic       txClk,
  input  logic       rst,
  input  logic       txDataValid,
  input  logic       txDataLast,
  input  logic [7:0] txData,
  output logic       txDataReady,
  output logic       txEn,
  output logic       txEr,
  output logic [7:0] txDataOut,
  output logic       txBusy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_BYTES - 1);
  localparam logic [4:0]  IFG_LAST = 5'(IFG_BYTES - 1);
  localparam logic [11:0] MIN_LEN  = 12'(MIN_PAYLOAD);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] count_q, count_d;
  logic [4:0]  phase_q, phase_d;
  logic        drop_q, drop_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [7:0]  dout_q, dout_d;

  logic        accept;
  logic [11:0] count_next;
  logic [10:0] count_sat;
  logic [31:0] fcs;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) begin
        r = (r >> 1) ^ 32'hEDB88320;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  assign accept     = txDataValid && ready_q;
  assign count_next = {1'b0, count_q} + 12'd1;
  assign count_sat  = (count_q == 11'h7FF) ? count_q : count_next[10:0];
  assign fcs        = ~crc_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    count_d = count_q;
    phase_d = phase_q;
    drop_d  = drop_q;
    en_d    = 1'b0;
    er_d    = 1'b0;
    dout_d  = 8'h00;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (txDataValid) begin
          state_d = S_PREAMBLE;
          crc_d   = 32'hFFFFFFFF;
          count_d = '0;
          phase_d = '0;
        end
      end

      S_PREAMBLE: begin
        en_d    = 1'b1;
        dout_d  = 8'h55;
        phase_d = phase_q + 5'd1;
        if (phase_q == PRE_LAST) begin
          state_d = S_SFD;
          phase_d = '0;
        end
      end

      S_SFD: begin
        en_d    = 1'b1;
        dout_d  = 8'hD5;
        ready_d = 1'b1;
        state_d = S_DATA;
      end

      S_DATA: begin
        if (accept) begin
          en_d    = 1'b1;
          dout_d  = txData;
          crc_d   = crc32_byte(crc_q, txData);
          count_d = count_sat;
          ready_d = 1'b1;
          if (txDataLast) begin
            ready_d = 1'b0;
            phase_d = '0;
            state_d = (count_next < MIN_LEN) ? S_PAD : S_FCS;
          end
        end else begin
          // Underrun: flag the frame as bad on the wire and drain the rest of it.
          en_d    = 1'b1;
          er_d    = 1'b1;
          dout_d  = 8'h00;
          drop_d  = 1'b1;
          ready_d = 1'b1;
          phase_d = '0;
          state_d = S_IFG;
        end
      end

      S_PAD: begin
        en_d    = 1'b1;
        dout_d  = 8'h00;
        crc_d   = crc32_byte(crc_q, 8'h00);
        count_d = count_sat;
        if (count_next >= MIN_LEN) begin
          phase_d = '0;
          state_d = S_FCS;
        end
      end

      S_FCS: begin
        en_d    = 1'b1;
        case (phase_q[1:0])
          2'd0:    dout_d = fcs[7:0];
          2'd1:    dout_d = fcs[15:8];
          2'd2:    dout_d = fcs[23:16];
          default: dout_d = fcs[31:24];
        endcase
        phase_d = phase_q + 5'd1;
        if (phase_q[1:0] == 2'd3) begin
          phase_d = '0;
          state_d = S_IFG;
        end
      end

      S_IFG: begin
        // Upstream bytes are only taken here while draining an underrun frame.
        if (drop_q && accept && txDataLast) begin
          drop_d = 1'b0;
        end
        ready_d = drop_d;
        if (phase_q != IFG_LAST) begin
          phase_d = phase_q + 5'd1;
        end else if (!drop_d) begin
          phase_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge txClk) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q   <= 32'hFFFFFFFF;
      count_q <= '0;
      phase_q <= '0;
      drop_q  <= 1'b0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      phase_q <= phase_d;
      drop_q  <= drop_d;
      en_q    <= en_d;
      er_q    <= er_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign txDataReady = ready_q;
  assign txEn        = en_q;
  assign txEr        = er_q;
  assign txDataOut   = dout_q;
  assign txBusy      = busy_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb/tb_rgmii_tx_framer.sv - randomized self-checking bench for rgmii_tx_framer
// Wire contents come from a queue-based frame model with a table-driven CRC.
module tb_rgmii_tx_framer;

  localparam int PRE  = 7;
  localparam int MINP = 60;
  localparam int IFG  = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int len;
    bit gap_exact;
    int lit_len;
  } frame_t;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst   = 1'b1;
  logic       valid = 1'b1;
  logic       last  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready, en, er, busy;
  logic [7:0] dout;
  logic       rst_s = 1'b1;

  logic       b_rst   = 1'b1;
  logic       b_valid = 1'b0;
  logic       b_last  = 1'b0;
  logic [7:0] b_data  = 8'h00;
  logic       b_ready, b_en, b_er, b_busy;
  logic [7:0] b_dout;
  bit         b_done = 1'b0;
  logic [8:0] b_cap[$];

  always @(posedge clk) rst_s <= rst;

  rgmii_tx_framer u_dut (
    .txClk(clk), .rst(rst), .txDataValid(valid), .txDataLast(last), .txData(data),
    .txDataReady(ready), .txEn(en), .txEr(er), .txDataOut(dout), .txBusy(busy)
  );

  rgmii_tx_framer #(.MIN_PAYLOAD(0)) u_dut0 (
    .txClk(clk), .rst(b_rst), .txDataValid(b_valid), .txDataLast(b_last), .txData(b_data),
    .txDataReady(b_ready), .txEn(b_en), .txEr(b_er), .txDataOut(b_dout), .txBusy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] crc_tab[256];
  logic [7:0]  pl[2048];
  logic [8:0]  exp_q[$];
  frame_t      fr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
    return c;
  endfunction

  task automatic push_expect(input int n, input int u, input bit gap_exact, input int lit_len);
    bq_t         body;
    logic [31:0] fcs;
    frame_t      f;
    for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (u >= 0) begin
      for (int i = 0; i < u; i++) exp_q.push_back({1'b0, pl[i]});
      exp_q.push_back({1'b1, 8'h00});
      f.len = PRE + 1 + u + 1;
    end else begin
      for (int i = 0; i < n; i++) body.push_back(pl[i]);
      while (body.size() < MINP) body.push_back(8'h00);
      fcs = ~ref_crc(body);
      foreach (body[i]) exp_q.push_back({1'b0, body[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
      f.len = PRE + 1 + body.size() + 4;
    end
    f.gap_exact = gap_exact;
    f.lit_len   = lit_len;
    fr_q.push_back(f);
  endtask

  task automatic send_frame(input int n, input int u, input int abort_at,
                            input bit gap_exact, input int lit_len);
    int idx;
    int guard;
    bit xfer;
    bit under_done;
    push_expect(n, u, gap_exact, lit_len);
    idx = 0;
    guard = 0;
    under_done = 1'b0;
    valid = 1'b1;
    data  = pl[0];
    last  = (n == 1);
    while (idx < n) begin
      @(negedge clk);
      xfer = valid && ready;
      @(posedge clk);
      #1;
      guard++;
      if (xfer) idx++;
      if (guard > 5000) begin
        check("send_timeout", idx, n);
        break;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst   = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (u >= 0 && idx == u && !under_done) begin
        valid = 1'b0;
        under_done = 1'b1;
      end else if (idx < n) begin
        valid = 1'b1;
        data  = pl[idx];
        last  = (idx == n - 1);
      end
    end
    valid = 1'b0;
    last  = 1'b0;
    check("bytes_accepted", idx, n);
    @(negedge clk);
    check("ready_after_last", ready, 0);
  endtask

  initial begin : compare
    int       remaining;
    int       gap;
    int       since_rst;
    int       cur_len;
    int       cur_exp;
    int       cur_lit;
    bit       have_prev;
    bit       after_rst;
    bit       prev_en;
    logic [8:0] e;
    frame_t   f;
    remaining = 0; gap = 0; since_rst = 0; cur_len = 0; cur_exp = 0; cur_lit = 0;
    have_prev = 0; after_rst = 1; prev_en = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        check("rst_en", en, 0);
        check("rst_er", er, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_data", dout, 0);
        while (remaining > 0 && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          remaining--;
        end
        remaining = 0; have_prev = 0; after_rst = 1; since_rst = 0; prev_en = 0;
        continue;
      end
      since_rst++;
      if (en && !prev_en) begin
        if (fr_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          f.len = 0; f.gap_exact = 0; f.lit_len = 0;
        end else begin
          f = fr_q.pop_front();
        end
        if (after_rst) check("rst_to_preamble", since_rst, 2);
        else if (have_prev && f.gap_exact) check("ifg_exact", gap, IFG + 1);
        else if (have_prev) check("ifg_min", gap >= IFG + 1, 1);
        remaining = f.len; cur_exp = f.len; cur_lit = f.lit_len; cur_len = 0;
        after_rst = 0;
      end
      if (en) begin
        if (remaining > 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          remaining--;
          check("wire_byte", {er, dout}, e);
        end else begin
          check("frame_overrun", 1, 0);
        end
        cur_len++;
        check("busy_when_en", busy, 1);
      end else begin
        check("idle_byte", {er, dout}, 9'h000);
        if (prev_en) begin
          check("frame_len", cur_len, cur_exp);
          if (cur_lit != 0) check("frame_len_literal", cur_len, cur_lit);
          have_prev = 1;
          gap = 0;
        end
        gap++;
        if (!busy) check("ready_when_idle", ready, 0);
      end
      prev_en = en;
    end
  end

  initial begin : b_monitor
    forever begin
      @(negedge clk);
      if (b_en) b_cap.push_back({b_er, b_dout});
    end
  end

  initial begin : min0_test
    logic [7:0] bexp[$];
    int idx;
    int guard;
    bit xfer;
    for (int i = 0; i < 7; i++) bexp.push_back(8'h55);
    bexp.push_back(8'hD5);
    for (int i = 0; i < 9; i++) bexp.push_back(8'(8'h31 + i));
    bexp.push_back(8'h26); bexp.push_back(8'h39); bexp.push_back(8'hF4); bexp.push_back(8'hCB);
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    b_valid = 1'b1; b_data = 8'h31; b_last = 1'b0;
    idx = 0; guard = 0;
    while (idx < 9 && guard < 200) begin
      @(negedge clk);
      xfer = b_valid && b_ready;
      @(posedge clk);
      #1;
      guard++;
      if (xfer) idx++;
      b_data = 8'(8'h31 + idx);
      b_last = (idx == 8);
    end
    b_valid = 1'b0; b_last = 1'b0;
    check("min0_bytes_accepted", idx, 9);
    repeat (40) @(posedge clk);
    check("min0_txen_cycles", b_cap.size(), 21);
    for (int i = 0; i < 21; i++) begin
      if (i < b_cap.size()) check("min0_wire_byte", b_cap[i], {1'b0, bexp[i]});
    end
    b_done = 1'b1;
  end

  initial begin : main
    int n;
    int k;
    int w;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) pl[i] = 8'(i);
    send_frame(10, -1, -1, 1'b1, 72);
    for (int i = 0; i < 1500; i++) pl[i] = 8'(i);
    send_frame(1500, -1, -1, 1'b1, 1512);

    for (int s = 0; s < 4; s++) begin
      n = (s == 0) ? 1 : 58 + s;
      for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
      send_frame(n, -1, -1, 1'b1, 0);
    end

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 130);
      k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(40, 60);
      for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
      send_frame(n, -1, -1, (k == 0), 0);
    end

    for (int i = 0; i < 100; i++) pl[i] = 8'($urandom);
    send_frame(100, 20, -1, 1'b1, 0);
    n = $urandom_range(20, 90);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    send_frame(n, -1, -1, 1'b0, 0);

    for (int i = 0; i < 80; i++) pl[i] = 8'($urandom);
    send_frame(80, -1, 30, 1'b1, 0);
    for (int i = 0; i < 45; i++) pl[i] = 8'($urandom);
    send_frame(45, -1, -1, 1'b0, 0);
    n = $urandom_range(61, 200);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    send_frame(n, -1, -1, 1'b1, 0);

    w = 0;
    while (busy && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_to_idle", busy, 0);
    repeat (5) @(posedge clk);
    check("pending_frames", fr_q.size(), 0);
    check("pending_bytes", exp_q.size(), 0);
    w = 0;
    while (!b_done && w < 400) begin
      @(posedge clk);
      w++;
    end
    check("min0_done", b_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
